// File: rtl/vn_mem_responder_if.sv
// Request/acknowledge bus between the control unit (master) and the unified memory (slave).
interface vn_mem_responder_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 4
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/vn_mem_responder.sv
// Unified program/data memory slave: req/ack single-word access with wait states,
// side-band loader port and optional post-reset zeroing of the whole array.
module vn_mem_responder #(
    parameter int unsigned AW             = 8,
    parameter int unsigned DW             = 4,
    parameter int unsigned WAIT_STATES    = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    vn_mem_responder_if.slave    bus,
    input  logic                 ld_we,
    input  logic [AW-1:0]        ld_addr,
    input  logic [DW-1:0]        ld_data
);

    typedef enum logic [1:0] {StClear, StIdle, StWait, StResp} state_e;

    localparam state_e     ResetState = (CLEAR_ON_RESET != 0) ? StClear : StIdle;
    localparam logic [2:0] WaitLoad   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
    localparam bit         NoWait     = (WAIT_STATES == 0);

    state_e        state_q;
    logic [2:0]    wait_cnt_q;
    logic [AW-1:0] clr_cnt_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          ack_q;

    logic [DW-1:0] mem [2**AW];

    logic          accept;
    logic          commit;
    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic [DW-1:0] acc_wdata;

    // With no wait states the commit edge is the accepting edge, so use the live bus fields.
    always_comb begin
        accept    = (state_q == StIdle) && bus.req;
        commit    = (accept && NoWait) || ((state_q == StWait) && (wait_cnt_q == 3'd0));
        acc_addr  = (state_q == StIdle) ? bus.addr  : addr_q;
        acc_we    = (state_q == StIdle) ? bus.we    : we_q;
        acc_wdata = (state_q == StIdle) ? bus.wdata : wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ResetState;
            wait_cnt_q <= 3'd0;
            clr_cnt_q  <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (commit) begin
                ack_q <= 1'b1;
                if (!acc_we) begin
                    rdata_q <= mem[acc_addr];
                end
            end
            unique case (state_q)
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (accept) begin
                        addr_q     <= bus.addr;
                        we_q       <= bus.we;
                        wdata_q    <= bus.wdata;
                        wait_cnt_q <= WaitLoad;
                        state_q    <= NoWait ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= ResetState;
            endcase
        end
    end

    // Array has no reset; the loader write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (commit && acc_we) begin
                mem[acc_addr] <= acc_wdata;
            end
            if (ld_we) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_vn_mem_responder.sv
// Bench for vn_mem_responder: three instances cover WAIT_STATES 1/0/3 and both clear modes.
module tb_vn_mem_responder;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 4;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_v     [N];
    logic          req_v     [N];
    logic          we_v      [N];
    logic [AW-1:0] addr_v    [N];
    logic [DW-1:0] wdata_v   [N];
    logic          ld_we_v   [N];
    logic [AW-1:0] ld_addr_v [N];
    logic [DW-1:0] ld_data_v [N];
    logic [DW-1:0] rdata_v   [N];
    logic          ack_v     [N];
    logic          busy_v    [N];

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q [$];

    for (genvar g = 0; g < N; g++) begin : g_dut
        vn_mem_responder_if #(.AW(AW), .DW(DW)) bus ();
        assign bus.req    = req_v[g];
        assign bus.we     = we_v[g];
        assign bus.addr   = addr_v[g];
        assign bus.wdata  = wdata_v[g];
        assign rdata_v[g] = bus.rdata;
        assign ack_v[g]   = bus.ack;
        assign busy_v[g]  = bus.busy;

        vn_mem_responder #(
            .AW            (AW),
            .DW            (DW),
            .WAIT_STATES   ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .CLEAR_ON_RESET((g == 0) ? 1 : 0)
        ) u_dut (
            .clk    (clk),
            .reset  (rst_v[g]),
            .bus    (bus),
            .ld_we  (ld_we_v[g]),
            .ld_addr(ld_addr_v[g]),
            .ld_data(ld_data_v[g])
        );
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    function automatic int ws_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_we_v[idx]   = 1'b1;
        ld_addr_v[idx] = a;
        ld_data_v[idx] = d;
        @(negedge clk);
        ld_we_v[idx]   = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic access(input int idx, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int n;
        logic [DW-1:0] e;
        exp_q.push_back(exp_rd);
        req_v[idx]   = 1'b1;
        we_v[idx]    = w;
        addr_v[idx]  = a;
        wdata_v[idx] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_v[idx] && n < 20);
        req_v[idx] = 1'b0;
        check("ack_latency", n, ws_of(idx) + 1);
        e = exp_q.pop_front();
        check("rdata_at_ack", rdata_v[idx], e);
        @(negedge clk);
        check("ack_one_cycle", ack_v[idx], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic seen;
        logic [DW-1:0] e;

        vecs[0]  = '{1'b0, 8'h55, 4'h0, 4'h0};
        vecs[1]  = '{1'b1, 8'h3C, 4'hA, 4'h0};
        vecs[2]  = '{1'b0, 8'h3C, 4'h0, 4'hA};
        vecs[3]  = '{1'b1, 8'h3D, 4'h3, 4'hA};
        vecs[4]  = '{1'b0, 8'h3D, 4'h0, 4'h3};
        vecs[5]  = '{1'b1, 8'hFF, 4'hE, 4'h3};
        vecs[6]  = '{1'b0, 8'hFF, 4'h0, 4'hE};
        vecs[7]  = '{1'b0, 8'h00, 4'h0, 4'h0};
        vecs[8]  = '{1'b1, 8'h00, 4'h1, 4'h0};
        vecs[9]  = '{1'b0, 8'h01, 4'h0, 4'h0};
        vecs[10] = '{1'b0, 8'h00, 4'h0, 4'h1};

        for (int i = 0; i < N; i++) begin
            rst_v[i]     = 1'b1;
            req_v[i]     = 1'b0;
            we_v[i]      = 1'b0;
            addr_v[i]    = '0;
            wdata_v[i]   = '0;
            ld_we_v[i]   = 1'b0;
            ld_addr_v[i] = '0;
            ld_data_v[i] = '0;
        end

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset_ack", ack_v[i], 1'b0);
            check("reset_rdata", rdata_v[i], 4'h0);
            check("reset_busy", busy_v[i], (i == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < N; i++) rst_v[i] = 1'b0;

        // Clear length; a loader write mid-clear to an already-cleared address must be dropped.
        cnt = 0;
        while (busy_v[0] && cnt < 1000) begin
            cnt++;
            if (cnt == 100) begin
                ld_we_v[0]   = 1'b1;
                ld_addr_v[0] = 8'h01;
                ld_data_v[0] = 4'h5;
            end else begin
                ld_we_v[0] = 1'b0;
            end
            @(negedge clk);
        end
        ld_we_v[0] = 1'b0;
        check("clear_busy_cycles", cnt, 256);

        for (int i = 0; i < 11; i++) begin
            access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        end
        repeat (3) begin
            @(negedge clk);
            check("rdata_hold_idle", rdata_v[0], 4'h1);
        end

        // Bus fields changed during WAIT must not affect the captured write.
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h10; wdata_v[0] = 4'h5;
        @(negedge clk);
        check("capture_wait_ack", ack_v[0], 1'b0);
        check("capture_wait_busy", busy_v[0], 1'b1);
        addr_v[0] = 8'h11; wdata_v[0] = 4'hF;
        @(negedge clk);
        check("capture_ack", ack_v[0], 1'b1);
        req_v[0] = 1'b0;
        @(negedge clk);
        access(0, 1'b0, 8'h10, 4'h0, 4'h5);
        access(0, 1'b0, 8'h11, 4'h0, 4'h0);

        // Loader and bus write to the same address on the commit edge.
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h20; wdata_v[0] = 4'h4;
        @(negedge clk);
        ld_we_v[0] = 1'b1; ld_addr_v[0] = 8'h20; ld_data_v[0] = 4'hC;
        @(negedge clk);
        check("coll_wr_ack", ack_v[0], 1'b1);
        ld_we_v[0] = 1'b0; req_v[0] = 1'b0;
        @(negedge clk);
        access(0, 1'b0, 8'h20, 4'h0, 4'hC);

        // Loader write and bus read commit to the same address: read sees the old word.
        load(0, 8'h30, 4'h3);
        exp_q.push_back(4'h3);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'h30;
        @(negedge clk);
        ld_we_v[0] = 1'b1; ld_addr_v[0] = 8'h30; ld_data_v[0] = 4'h8;
        @(negedge clk);
        check("coll_rd_ack", ack_v[0], 1'b1);
        e = exp_q.pop_front();
        check("coll_rd_rdata", rdata_v[0], e);
        ld_we_v[0] = 1'b0; req_v[0] = 1'b0;
        @(negedge clk);
        access(0, 1'b0, 8'h30, 4'h0, 4'h8);

        // Back-to-back reads with no wait states and req held high.
        load(1, 8'h01, 4'h7);
        load(1, 8'h02, 4'h9);
        exp_q.push_back(4'h7);
        exp_q.push_back(4'h9);
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 8'h01;
        @(negedge clk);
        check("b2b_ack1", ack_v[1], 1'b1);
        e = exp_q.pop_front();
        check("b2b_rdata1", rdata_v[1], e);
        addr_v[1] = 8'h02;
        @(negedge clk);
        check("b2b_gap", ack_v[1], 1'b0);
        @(negedge clk);
        check("b2b_ack2", ack_v[1], 1'b1);
        e = exp_q.pop_front();
        check("b2b_rdata2", rdata_v[1], e);
        req_v[1] = 1'b0;
        @(negedge clk);
        check("b2b_end", ack_v[1], 1'b0);
        access(1, 1'b1, 8'h80, 4'hB, 4'h9);
        access(1, 1'b0, 8'h80, 4'h0, 4'hB);

        // Reset in the second wait cycle of a write abandons it.
        load(2, 8'h40, 4'h2);
        access(2, 1'b0, 8'h40, 4'h0, 4'h2);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 8'h40; wdata_v[2] = 4'h6;
        @(negedge clk);
        check("midwait_busy", busy_v[2], 1'b1);
        @(negedge clk);
        rst_v[2] = 1'b1;
        req_v[2] = 1'b0;
        #1;
        check("midwait_rst_ack", ack_v[2], 1'b0);
        check("midwait_rst_busy", busy_v[2], 1'b0);
        @(negedge clk);
        rst_v[2] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack_v[2]) seen = 1'b1;
        end
        check("midwait_no_ack", seen, 1'b0);
        access(2, 1'b0, 8'h40, 4'h0, 4'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
